dense_mac_array: RTL and testbench
==================================

// Module: dense_mac_array
// PURPOSE
//  N_OUT-lane signed multiply-accumulate engine for dense (fully connected) layers; successor to the single-lane accumulator.
//  Streams one activation per enabled beat, multiplies it by N_OUT per-lane weights and accumulates over a frame from a bias preload.
//  At frame end, each sum is shifted, optionally ReLU'd and saturated; results are held under a valid/ready handshake for downstream.
// PARAMETERS
//  DATA_W   8   signed activation width (dense_input)
//  WGT_W    8   signed weight width per lane
//  ACC_W    24  signed accumulator/bias width per lane
//  OUT_W    16  signed output width per lane
//  N_OUT    4   number of output lanes (neurons) computed in parallel
//  SHIFT    0   arithmetic right shift applied to accumulator before output saturation
//  RELU_EN  1   1: negative results clamp to 0 at output; 0: signed passthrough
//  CNT_W    16  width of beat counter
// PORTS
//  clk             input   1             rising-edge clock
//  rst             input   1             asynchronous active-high reset
//  ena             input   1             data beat qualifier for dense_input / weight_in
//  frame_start_in  input   1             one-cycle pulse opening a frame; samples bias_in
//  frame_end_in    input   1             marks last beat (included if ena=1 same cycle)
//  dense_input     input   DATA_W        signed activation
//  weight_in       input   N_OUT*WGT_W   signed weights, lane k at [k*WGT_W +: WGT_W]
//  bias_in         input   N_OUT*ACC_W   signed biases, lane k at [k*ACC_W +: ACC_W]
//  out_ready       input   1             downstream accepts result when high with valid
//  dense_sum_out   output  N_OUT*OUT_W   signed results, lane k at [k*OUT_W +: OUT_W]
//  valid           output  1             results valid; held until out_ready
//  busy            output  1             high in ACC/DRAIN/HOLD
//  beat_count      output  CNT_W         beats accepted in current/last frame (saturates at all-ones)
//  overflow        output  1             sticky: accumulator or output saturated this frame
//  frame_err       output  1             sticky: protocol violation; cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0, accumulators 0, pipeline flags 0, state IDLE.
//  FSM: IDLE -frame_start_in-> ACC; ACC -frame_end_in-> DRAIN; DRAIN (3 cycles) -> HOLD; HOLD -valid&out_ready-> IDLE.
//  IDLE: ena/frame_end_in ignored. frame_start_in: acc[k]<=bias[k], beat_count<=0, overflow<=0.
//  ACC: each ena=1 beat sets p[k]<=x*w[k] (full DATA_W+WGT_W product) next edge; acc[k]+=sext(p[k]) edge after.
//  Accumulate saturates at ACC_W signed min/max (no wrap) and sets overflow.
//  Latency: last beat sampled at edge t -> product t+1 -> accumulate t+2 -> dense_sum_out registered, valid=1 after edge t+3.
//  frame_end_in with ena=0 closes frame without adding a beat; a frame of zero beats outputs the biases (post-process).
//  Output per lane: s = acc>>>SHIFT; if RELU_EN and s<0 then s=0; saturate to OUT_W signed; saturation sets overflow.
//  HOLD: dense_sum_out and valid stable until out_ready=1; on that edge valid<=0, outputs keep last value, state IDLE.
//  out_ready ignored when valid=0. frame_start_in same cycle as accepting handshake is accepted (back-to-back frames).
//  frame_start_in in ACC: restart — acc reloaded with bias, in-flight products discarded, beat_count<=0, frame_err<=1.
//  frame_start_in in DRAIN or HOLD (not handshake cycle): ignored, frame_err<=1.
//  frame_start_in and frame_end_in same cycle in IDLE: start wins, end ignored, frame_err<=1.
//  Async rst mid-frame: immediate clear to reset state; partial sums lost.
// TESTING
//  1 N_OUT=4, w={1,2,-1,0}, bias 0, 5x14x14 beats x=i+j, end on last beat -> out {12740,25480,0,0}, valid 3 cycles after last beat, beat_count=980.
//  2 RELU_EN=0 same stimulus -> lane2 = -12740; bias {100,-50,0,7}, 3 beats x=3, w=2 all lanes -> {118,-32,18,25}.
//  3 x=127, w=127, 3 beats (48387) -> out 32767, overflow=1; x=-128,w=127 RELU_EN=0 -> out -32768, overflow=1.
//  4 out_ready low 10 cycles after valid -> valid and data stable; frame_start_in during HOLD -> ignored, frame_err=1; ready -> IDLE.
//  5 rst pulse after 50 beats -> all outputs 0 immediately; next frame of 2 beats x=1,w=1 -> {2,2,2,2}, overflow=0.
//  6 frame_start_in mid-ACC after 20 beats, then 4 beats x=1,w=1, bias 0 -> out {4,4,4,4}, beat_count=4, frame_err=1.

Source files
------------

// File: rtl/dense_mac_array.sv
// ----------------------------------------------------------------------------
// dense_mac_array
//   N_OUT-lane signed multiply-accumulate engine for dense layers. Each
//   enabled beat multiplies one activation by N_OUT per-lane weights. The
//   products are accumulated over a frame, starting from a bias preload.
//   At frame end every sum is arithmetically shifted, optionally ReLU'd and
//   saturated to OUT_W. The results are then held until out_ready is seen.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   ena            beat qualifier for dense_input / weight_in
//   frame_start_in one-cycle frame open pulse; samples bias_in
//   frame_end_in   marks the last beat (the beat counts if ena=1 too)
//   dense_input    signed activation
//   weight_in      signed weights, lane k at [k*WGT_W +: WGT_W]
//   bias_in        signed biases, lane k at [k*ACC_W +: ACC_W]
//   out_ready      downstream accept, qualified by valid
//   dense_sum_out  signed results, lane k at [k*OUT_W +: OUT_W]
//   valid          results valid, held until accepted
//   busy           high while a frame is in ACC, DRAIN or HOLD
//   beat_count     beats accepted in the current/last frame (saturating)
//   overflow       sticky per frame: accumulator or output saturated
//   frame_err      sticky protocol-violation flag, cleared only by rst
// ----------------------------------------------------------------------------
module dense_mac_array #(
    parameter int DATA_W  = 8,
    parameter int WGT_W   = 8,
    parameter int ACC_W   = 24,
    parameter int OUT_W   = 16,
    parameter int N_OUT   = 4,
    parameter int SHIFT   = 0,
    parameter int RELU_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     frame_start_in,
    input  logic                     frame_end_in,
    input  logic signed [DATA_W-1:0] dense_input,
    input  logic [N_OUT*WGT_W-1:0]   weight_in,
    input  logic [N_OUT*ACC_W-1:0]   bias_in,
    input  logic                     out_ready,
    output logic [N_OUT*OUT_W-1:0]   dense_sum_out,
    output logic                     valid,
    output logic                     busy,
    output logic [CNT_W-1:0]         beat_count,
    output logic                     overflow,
    output logic                     frame_err
);

    localparam int PROD_W = DATA_W + WGT_W;
    localparam int SUM_W  = ACC_W + 1;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OUT_MAX_A = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN_A = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_MAX_A[OUT_W-1:0];
    localparam logic [OUT_W-1:0] OUT_MIN = OUT_MIN_A[OUT_W-1:0];

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_HOLD} state_t;

    // Saturating accumulate; the MSB of the result flags saturation.
    function automatic logic [ACC_W:0] acc_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [PROD_W-1:0] p);
        logic signed [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(p);
        if (s[ACC_W] != s[ACC_W-1])
            acc_add = s[ACC_W] ? {1'b1, ACC_MIN} : {1'b1, ACC_MAX};
        else
            acc_add = {1'b0, s[ACC_W-1:0]};
    endfunction

    // Shift, optional ReLU, then saturate to OUT_W; MSB flags saturation.
    // ReLU clamping itself is not counted as saturation.
    function automatic logic [OUT_W:0] post_proc(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> SHIFT;
        if (RELU_EN != 0 && s[ACC_W-1])
            s = '0;
        if (s > OUT_MAX_A)
            post_proc = {1'b1, OUT_MAX};
        else if (s < OUT_MIN_A)
            post_proc = {1'b1, OUT_MIN};
        else
            post_proc = {1'b0, s[OUT_W-1:0]};
    endfunction

    state_t                    r_state;
    logic [1:0]                r_drain_cnt;
    logic                      r_vld_p0;
    logic                      r_vld_p1;
    logic signed [ACC_W-1:0]   r_acc [N_OUT];
    logic [N_OUT*OUT_W-1:0]    r_out;
    logic                      r_valid;
    logic [CNT_W-1:0]          r_beat_count;
    logic                      r_overflow;
    logic                      r_frame_err;

    logic signed [DATA_W-1:0]  r_x_p0;
    logic signed [WGT_W-1:0]   r_w_p0 [N_OUT];
    logic signed [PROD_W-1:0]  r_prod_p1 [N_OUT];

    logic                      w_beat;
    logic                      w_start;
    logic signed [ACC_W-1:0]   w_acc_nxt [N_OUT];
    logic [N_OUT-1:0]          w_acc_sat;
    logic [OUT_W-1:0]          w_out_nxt [N_OUT];
    logic [N_OUT-1:0]          w_out_sat;

    // A beat only counts inside ACC; a start pulse in the same cycle wins.
    assign w_beat  = (r_state == S_ACC) && ena && !frame_start_in;
    // Accepted frame opens: from IDLE, restart in ACC, or on the accepting
    // handshake in HOLD (back-to-back frames).
    assign w_start = frame_start_in &&
                     ((r_state == S_IDLE) || (r_state == S_ACC) ||
                      (r_state == S_HOLD && r_valid && out_ready));

    always_comb begin
        w_acc_sat = '0;
        w_out_sat = '0;
        for (int k = 0; k < N_OUT; k++) begin
            {w_acc_sat[k], w_acc_nxt[k]} = acc_add(r_acc[k], r_prod_p1[k]);
            {w_out_sat[k], w_out_nxt[k]} = post_proc(r_acc[k]);
        end
    end

    // Stage p0: capture activation and weights of an accepted beat.
    // Stage p1: full-precision per-lane product.
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_x_p0 <= dense_input;
            for (int k = 0; k < N_OUT; k++)
                r_w_p0[k] <= $signed(weight_in[k*WGT_W +: WGT_W]);
        end
        for (int k = 0; k < N_OUT; k++)
            r_prod_p1[k] <= PROD_W'(r_x_p0) * PROD_W'(r_w_p0[k]);
    end

    // Stage p2: accumulate; then frame control and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_drain_cnt  <= '0;
            r_vld_p0     <= 1'b0;
            r_vld_p1     <= 1'b0;
            for (int k = 0; k < N_OUT; k++)
                r_acc[k] <= '0;
            r_out        <= '0;
            r_valid      <= 1'b0;
            r_beat_count <= '0;
            r_overflow   <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_vld_p0 <= w_beat;
            // A restart discards the product still in flight.
            r_vld_p1 <= r_vld_p0 && !w_start;

            if (w_start) begin
                for (int k = 0; k < N_OUT; k++)
                    r_acc[k] <= $signed(bias_in[k*ACC_W +: ACC_W]);
                r_beat_count <= '0;
                r_overflow   <= 1'b0;
            end else begin
                if (r_vld_p1) begin
                    for (int k = 0; k < N_OUT; k++)
                        r_acc[k] <= w_acc_nxt[k];
                    if (|w_acc_sat)
                        r_overflow <= 1'b1;
                end
                if (w_beat && r_beat_count != '1)
                    r_beat_count <= r_beat_count + CNT_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (frame_start_in) begin
                        r_state <= S_ACC;
                        if (frame_end_in)
                            r_frame_err <= 1'b1;
                    end
                end
                S_ACC: begin
                    if (frame_start_in) begin
                        r_frame_err <= 1'b1;
                    end else if (frame_end_in) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    if (frame_start_in)
                        r_frame_err <= 1'b1;
                    // Three cycles lets the last beat pass p0, p1 and the
                    // accumulator before the result is registered.
                    if (r_drain_cnt == 2'd2) begin
                        for (int k = 0; k < N_OUT; k++)
                            r_out[k*OUT_W +: OUT_W] <= w_out_nxt[k];
                        if (|w_out_sat)
                            r_overflow <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= S_HOLD;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                    end
                end
                S_HOLD: begin
                    if (r_valid && out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= frame_start_in ? S_ACC : S_IDLE;
                    end else if (frame_start_in) begin
                        r_frame_err <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dense_sum_out = r_out;
    assign valid         = r_valid;
    assign busy          = (r_state != S_IDLE);
    assign beat_count    = r_beat_count;
    assign overflow      = r_overflow;
    assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_dense_mac_array.sv
module tb_dense_mac_array;

    logic               clk = 1'b0;
    logic               rst;
    logic               ena;
    logic               frame_start_in;
    logic               frame_end_in;
    logic signed [7:0]  dense_input;
    logic [31:0]        weight_in;
    logic [95:0]        bias_in;
    logic               out_ready;

    // Instance with ReLU (default parameters)
    logic [63:0]        sum_r;
    logic               valid_r, busy_r, ovf_r, err_r;
    logic [15:0]        bc_r;
    // Instance without ReLU, same stimulus
    logic [63:0]        sum_n;
    logic               valid_n, busy_n, ovf_n, err_n;
    logic [15:0]        bc_n;

    int n_chk = 0;
    int n_err = 0;

    dense_mac_array #(.RELU_EN(1)) u_dut (
        .clk(clk), .rst(rst), .ena(ena),
        .frame_start_in(frame_start_in), .frame_end_in(frame_end_in),
        .dense_input(dense_input), .weight_in(weight_in), .bias_in(bias_in),
        .out_ready(out_ready), .dense_sum_out(sum_r), .valid(valid_r),
        .busy(busy_r), .beat_count(bc_r), .overflow(ovf_r), .frame_err(err_r)
    );

    dense_mac_array #(.RELU_EN(0)) u_dut_nr (
        .clk(clk), .rst(rst), .ena(ena),
        .frame_start_in(frame_start_in), .frame_end_in(frame_end_in),
        .dense_input(dense_input), .weight_in(weight_in), .bias_in(bias_in),
        .out_ready(out_ready), .dense_sum_out(sum_n), .valid(valid_n),
        .busy(busy_n), .beat_count(bc_n), .overflow(ovf_n), .frame_err(err_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint lane_r(input int k);
        logic signed [15:0] v;
        v = sum_r[k*16 +: 16];
        return longint'(v);
    endfunction

    function automatic longint lane_n(input int k);
        logic signed [15:0] v;
        v = sum_n[k*16 +: 16];
        return longint'(v);
    endfunction

    function automatic logic [31:0] pack_w(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [95:0] pack_b(input int a, input int b, input int c, input int d);
        return {24'(d), 24'(c), 24'(b), 24'(a)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [95:0] b);
        bias_in        = b;
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
    endtask

    task automatic beat(input int x, input logic [31:0] w, input logic last);
        dense_input  = 8'(x);
        weight_in    = w;
        ena          = 1'b1;
        frame_end_in = last;
        tick();
        ena          = 1'b0;
        frame_end_in = 1'b0;
    endtask

    // Counts cycles until valid rises; bounded so a dead DUT cannot hang.
    task automatic wait_valid(output int n);
        n = 0;
        while (!valid_r && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic chk_lanes(input string tag, input bit relu,
                             input longint e0, input longint e1,
                             input longint e2, input longint e3);
        longint e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int k = 0; k < 4; k++) begin
            if (relu)
                chk($sformatf("%s_relu_lane%0d", tag, k), lane_r(k), e[k]);
            else
                chk($sformatf("%s_lin_lane%0d", tag, k), lane_n(k), e[k]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; ena = 1'b0; frame_start_in = 1'b0; frame_end_in = 1'b0;
        dense_input = '0; weight_in = '0; bias_in = '0; out_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_valid", valid_r, 0);
        chk("rst_valid_nr", valid_n, 0);
        chk("rst_busy", busy_r, 0);
        chk("rst_busy_nr", busy_n, 0);
        chk("rst_count", bc_r, 0);
        chk("rst_ovf", ovf_r, 0);
        chk("rst_err", err_r, 0);
        chk("rst_sum", sum_r, 0);
        tick();
        rst = 1'b0;
        tick();

        // Beats in IDLE are ignored
        beat(5, pack_w(1, 1, 1, 1), 1'b0);
        beat(5, pack_w(1, 1, 1, 1), 1'b1);
        chk("idle_busy", busy_r, 0);
        chk("idle_count", bc_r, 0);

        // Test 1: 5 x 14 x 14 beats, x=i+j, w={1,2,-1,0}
        start_frame(pack_b(0, 0, 0, 0));
        for (int r = 0; r < 5; r++)
            for (int i = 0; i < 14; i++)
                for (int j = 0; j < 14; j++)
                    beat(i + j, pack_w(1, 2, -1, 0), (r == 4 && i == 13 && j == 13));
        wait_valid(n);
        chk("t1_latency", n, 3);
        chk_lanes("t1", 1'b1, 12740, 25480, 0, 0);
        chk_lanes("t1", 1'b0, 12740, 25480, -12740, 0);
        chk("t1_count", bc_r, 980);
        chk("t1_count_nr", bc_n, 980);
        chk("t1_ovf", ovf_r, 0);
        accept();
        chk("t1_valid_drop", valid_r, 0);
        chk("t1_idle", busy_r, 0);

        // Test 2: bias preload, 3 beats x=3 w=2
        start_frame(pack_b(100, -50, 0, 7));
        for (int i = 0; i < 3; i++)
            beat(3, pack_w(2, 2, 2, 2), (i == 2));
        wait_valid(n);
        chk_lanes("t2", 1'b0, 118, -32, 18, 25);
        chk_lanes("t2", 1'b1, 118, 0, 18, 25);
        accept();

        // Test 3a: positive output saturation
        start_frame(pack_b(0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            beat(127, pack_w(127, 127, 127, 127), (i == 2));
        wait_valid(n);
        chk("t3a_relu_lane0", lane_r(0), 32767);
        chk("t3a_lin_lane3", lane_n(3), 32767);
        chk("t3a_ovf", ovf_r, 1);
        accept();

        // Test 3b: negative output saturation
        start_frame(pack_b(0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            beat(-128, pack_w(127, 127, 127, 127), (i == 2));
        wait_valid(n);
        chk_lanes("t3b", 1'b0, -32768, -32768, -32768, -32768);
        chk("t3b_ovf_nr", ovf_n, 1);
        chk("t3b_relu_lane0", lane_r(0), 0);
        chk("t3b_ovf_relu", ovf_r, 0);
        accept();

        // Zero-beat frame outputs the post-processed biases
        start_frame(pack_b(5, -3, 40000, -40000));
        frame_end_in = 1'b1;
        tick();
        frame_end_in = 1'b0;
        wait_valid(n);
        chk("t7_latency", n, 3);
        chk_lanes("t7", 1'b0, 5, -3, 32767, -32768);
        chk_lanes("t7", 1'b1, 5, 0, 32767, 0);
        chk("t7_count", bc_r, 0);
        chk("t7_ovf", ovf_r, 1);
        accept();
        chk("t7_ovf_cleared_next", ovf_r, 1);

        // Test 4: hold under backpressure, start during HOLD ignored
        chk("t4_err_clean", err_r, 0);
        start_frame(pack_b(0, 0, 0, 0));
        beat(2, pack_w(3, 3, 3, 3), 1'b1);
        wait_valid(n);
        for (int c = 0; c < 10; c++) begin
            if (c == 5) begin
                frame_start_in = 1'b1;
                tick();
                frame_start_in = 1'b0;
            end else begin
                tick();
            end
            chk($sformatf("t4_hold_valid%0d", c), valid_r, 1);
            chk($sformatf("t4_hold_lane0_%0d", c), lane_r(0), 6);
        end
        chk("t4_err", err_r, 1);
        chk("t4_busy", busy_r, 1);
        accept();
        chk("t4_valid_drop", valid_r, 0);
        chk("t4_idle", busy_r, 0);
        chk("t4_data_kept", lane_r(3), 6);

        // Test 5: async reset mid-frame
        start_frame(pack_b(9, 9, 9, 9));
        for (int i = 0; i < 50; i++)
            beat(1, pack_w(1, 1, 1, 1), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", busy_r, 0);
        chk("t5_rst_count", bc_r, 0);
        chk("t5_rst_err", err_r, 0);
        chk("t5_rst_sum", sum_r, 0);
        tick();
        rst = 1'b0;
        tick();
        start_frame(pack_b(0, 0, 0, 0));
        beat(1, pack_w(1, 1, 1, 1), 1'b0);
        beat(1, pack_w(1, 1, 1, 1), 1'b1);
        wait_valid(n);
        chk_lanes("t5", 1'b1, 2, 2, 2, 2);
        chk("t5_ovf", ovf_r, 0);
        accept();

        // Test 6: restart in ACC discards partial sum and in-flight beats
        start_frame(pack_b(0, 0, 0, 0));
        for (int i = 0; i < 20; i++)
            beat(1, pack_w(1, 1, 1, 1), 1'b0);
        chk("t6_err_before", err_r, 0);
        start_frame(pack_b(0, 0, 0, 0));
        chk("t6_err_after", err_r, 1);
        chk("t6_err_after_nr", err_n, 1);
        for (int i = 0; i < 4; i++)
            beat(1, pack_w(1, 1, 1, 1), (i == 3));
        wait_valid(n);
        chk_lanes("t6", 1'b1, 4, 4, 4, 4);
        chk("t6_count", bc_r, 4);
        accept();

        // Start and end together in IDLE: start wins, flagged as error
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        bias_in        = pack_b(0, 0, 0, 0);
        frame_start_in = 1'b1;
        frame_end_in   = 1'b1;
        tick();
        frame_start_in = 1'b0;
        frame_end_in   = 1'b0;
        chk("t8_err", err_r, 1);
        for (int i = 0; i < 5; i++)
            tick();
        chk("t8_still_acc", busy_r, 1);
        chk("t8_no_valid", valid_r, 0);
        beat(7, pack_w(1, -1, 2, 0), 1'b1);
        wait_valid(n);
        chk_lanes("t8", 1'b0, 7, -7, 14, 0);
        chk("t8_count", bc_r, 1);
        accept();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
